// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if
//   Bundles the three-master request side and the single-slave side of the
//   Wishbone arbiter.  Master m occupies bit m of the 3-bit vectors, nibble m
//   of the strobe vector and word m of the address/data vectors.
//   Modports:
//     slave  - the arbiter: takes master requests and slave responses,
//              drives the slave bus and the per-master responses.
//     master - the environment driving requests and slave responses.
interface wb_arbiter_if;
    logic [2:0]  i_m_wb_cyc;
    logic [11:0] i_m_wb_stb;
    logic [2:0]  i_m_wb_we;
    logic [95:0] i_m_wb_addr;
    logic [95:0] i_m_wb_dat;
    logic [31:0] o_m_wb_dat;
    logic [2:0]  o_m_wb_ack;
    logic [2:0]  o_m_wb_err;

    logic        o_wb_cyc;
    logic [3:0]  o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_dat;
    logic [31:0] i_wb_dat;
    logic        i_wb_ack;
    logic        i_wb_err;

    modport slave (
        input  i_m_wb_cyc, i_m_wb_stb, i_m_wb_we, i_m_wb_addr, i_m_wb_dat,
        output o_m_wb_dat, o_m_wb_ack, o_m_wb_err,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat,
        input  i_wb_dat, i_wb_ack, i_wb_err
    );

    modport master (
        output i_m_wb_cyc, i_m_wb_stb, i_m_wb_we, i_m_wb_addr, i_m_wb_dat,
        input  o_m_wb_dat, o_m_wb_ack, o_m_wb_err,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat,
        output i_wb_dat, i_wb_ack, i_wb_err
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Round-robin arbiter giving three Wishbone masters (0 fetch, 1 load,
//   2 store) access to one slave, with an optional bus-cycle timeout.
//   Ports:
//     i_clk      - clock, all state on the rising edge
//     i_reset_n  - asynchronous active-low reset (release synchronised outside)
//     bus        - wb_arbiter_if.slave, master requests / slave bus / responses
//     o_grant    - one-hot current owner, 0 while idle
//     o_timeout  - one-cycle pulse the cycle after a timeout error
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no owner, slave bus driven to 0, responses ignored
//   BUSY  | owner in r_grant, its request copied to the slave bus
module wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    wb_arbiter_if.slave     bus,
    output logic [2:0]      o_grant,
    output logic            o_timeout
);
    localparam int TMR_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_grant, w_grant_nxt;
    logic [1:0]         r_last, w_last_nxt;
    logic [TMR_W-1:0]   r_timer, w_timer_nxt;
    logic               r_timeout, w_timeout_nxt;

    logic [1:0]         w_winner;
    logic               w_active;
    logic               w_resp;
    logic               w_tmo_hit;

    // Round-robin: search upward from the master after the last winner.
    always_comb begin
        w_winner = 2'd0;
        case (r_last)
            2'd0: w_winner = bus.i_m_wb_cyc[1] ? 2'd1 : (bus.i_m_wb_cyc[2] ? 2'd2 : 2'd0);
            2'd1: w_winner = bus.i_m_wb_cyc[2] ? 2'd2 : (bus.i_m_wb_cyc[0] ? 2'd0 : 2'd1);
            default: w_winner = bus.i_m_wb_cyc[0] ? 2'd0 : (bus.i_m_wb_cyc[1] ? 2'd1 : 2'd2);
        endcase
    end

    // Owner still holding cyc; a dropped cyc ends the cycle without responses.
    assign w_active  = (r_state == ST_BUSY) && |(r_grant & bus.i_m_wb_cyc);
    assign w_resp    = bus.i_wb_ack | bus.i_wb_err;
    // A real slave response in the same cycle takes precedence over the timeout.
    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_timer == TMO_LAST) && !w_resp;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= 3'b000;
            r_last    <= 2'd2;
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_last    <= w_last_nxt;
            r_timer   <= w_timer_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_last_nxt    = r_last;
        w_timer_nxt   = r_timer;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|bus.i_m_wb_cyc) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = 3'b001 << w_winner;
                    w_last_nxt  = w_winner;
                    w_timer_nxt = '0;
                end
            end
            default: begin
                if (!w_active || w_resp) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 3'b000;
                end else if (w_tmo_hit) begin
                    w_state_nxt   = ST_IDLE;
                    w_grant_nxt   = 3'b000;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        bus.o_wb_cyc  = 1'b0;
        bus.o_wb_stb  = 4'b0000;
        bus.o_wb_we   = 1'b0;
        bus.o_wb_addr = 32'h0;
        bus.o_wb_dat  = 32'h0;
        bus.o_m_wb_ack = 3'b000;
        bus.o_m_wb_err = 3'b000;
        if (r_state == ST_BUSY) begin
            for (int m = 0; m < 3; m++) begin
                if (r_grant[m]) begin
                    bus.o_wb_cyc  = bus.i_m_wb_cyc[m];
                    bus.o_wb_stb  = bus.i_m_wb_stb[4*m +: 4];
                    bus.o_wb_we   = bus.i_m_wb_we[m];
                    bus.o_wb_addr = bus.i_m_wb_addr[32*m +: 32];
                    bus.o_wb_dat  = bus.i_m_wb_dat[32*m +: 32];
                end
            end
        end
        if (w_active) begin
            bus.o_m_wb_ack = r_grant & {3{bus.i_wb_ack}};
            bus.o_m_wb_err = r_grant & {3{bus.i_wb_err | w_tmo_hit}};
        end
    end

    assign bus.o_m_wb_dat = bus.i_wb_dat;
    assign o_grant        = r_grant;
    assign o_timeout      = r_timeout;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
//   Directed bench for wb_arbiter (TIMEOUT_CYCLES=4).  Inputs change 1 ns
//   after a rising edge, outputs are compared 2 ns after it.
module tb_wb_arbiter;
    logic       i_clk;
    logic       i_reset_n;
    logic [2:0] o_grant;
    logic       o_timeout;
    int         n_total;
    int         n_bad;

    wb_arbiter_if bus ();

    wb_arbiter #(.TIMEOUT_CYCLES(4)) u_dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus),
        .o_grant   (o_grant),
        .o_timeout (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  exp_g [4];
        logic [31:0] exp_a [4];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        exp_a[0] = 32'h1000; exp_a[1] = 32'h2000; exp_a[2] = 32'h3000; exp_a[3] = 32'h1000;
        n_total = 0;
        n_bad   = 0;

        i_reset_n       = 1'b0;
        bus.i_m_wb_cyc  = 3'b000;
        bus.i_m_wb_stb  = 12'h000;
        bus.i_m_wb_we   = 3'b000;
        bus.i_m_wb_addr = 96'h0;
        bus.i_m_wb_dat  = 96'h0;
        bus.i_wb_dat    = 32'h0;
        bus.i_wb_ack    = 1'b1;
        bus.i_wb_err    = 1'b0;

        // reset state, slave ack must not leak
        #3;
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_cyc", 32'(bus.o_wb_cyc), 0);
        chk("rst_timeout", 32'(o_timeout), 0);
        chk("rst_ack", 32'(bus.o_m_wb_ack), 0);
        bus.i_wb_ack = 1'b0;
        #4;
        i_reset_n = 1'b1;

        // single store, ack in 3rd BUSY cycle
        bus.i_m_wb_cyc  = 3'b100;
        bus.i_m_wb_stb  = 12'h300;
        bus.i_m_wb_we   = 3'b100;
        bus.i_m_wb_addr = {32'h1000, 32'h0, 32'h0};
        bus.i_m_wb_dat  = {32'hDEADBEEF, 32'h0, 32'h0};
        settle();
        chk("st_cyc_c0", 32'(bus.o_wb_cyc), 0);
        tick(); settle();
        chk("st_grant", 32'(o_grant), 32'h4);
        chk("st_cyc_c1", 32'(bus.o_wb_cyc), 1);
        chk("st_stb", 32'(bus.o_wb_stb), 32'h3);
        chk("st_we", 32'(bus.o_wb_we), 1);
        chk("st_addr", bus.o_wb_addr, 32'h1000);
        chk("st_dat", bus.o_wb_dat, 32'hDEADBEEF);
        tick(); settle();
        chk("st_noack_c2", 32'(bus.o_m_wb_ack), 0);
        tick();
        bus.i_wb_ack = 1'b1;
        bus.i_wb_dat = 32'h12345678;
        settle();
        chk("st_ack", 32'(bus.o_m_wb_ack), 32'h4);
        chk("st_err", 32'(bus.o_m_wb_err), 0);
        chk("st_rdat", bus.o_m_wb_dat, 32'h12345678);
        tick();
        bus.i_wb_ack   = 1'b0;
        bus.i_m_wb_cyc = 3'b000;
        settle();
        chk("st_grant_end", 32'(o_grant), 0);
        chk("st_cyc_end", 32'(bus.o_wb_cyc), 0);

        // all three requesting, ack in first BUSY cycle
        bus.i_m_wb_cyc  = 3'b111;
        bus.i_m_wb_we   = 3'b000;
        bus.i_m_wb_stb  = 12'hFFF;
        bus.i_m_wb_addr = {32'h3000, 32'h2000, 32'h1000};
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            chk($sformatf("rr_grant%0d", i), 32'(o_grant), 32'(exp_g[i]));
            chk($sformatf("rr_addr%0d", i), bus.o_wb_addr, exp_a[i]);
            bus.i_wb_ack = 1'b1;
            settle();
            chk($sformatf("rr_ack%0d", i), 32'(bus.o_m_wb_ack), 32'(exp_g[i]));
            tick();
            bus.i_wb_ack = 1'b0;
            settle();
            chk($sformatf("rr_idle%0d", i), 32'(o_grant), 0);
            chk($sformatf("rr_idlecyc%0d", i), 32'(bus.o_wb_cyc), 0);
        end
        bus.i_m_wb_cyc = 3'b000;

        // load, slave silent -> timeout in 4th BUSY cycle
        bus.i_m_wb_cyc = 3'b010;
        tick(); settle();
        chk("to_grant", 32'(o_grant), 32'h2);
        chk("to_err_c1", 32'(bus.o_m_wb_err), 0);
        tick(); tick(); settle();
        chk("to_err_c3", 32'(bus.o_m_wb_err), 0);
        tick(); settle();
        chk("to_err_c4", 32'(bus.o_m_wb_err), 32'h2);
        chk("to_pulse_early", 32'(o_timeout), 0);
        tick();
        bus.i_m_wb_cyc = 3'b000;
        bus.i_wb_ack   = 1'b1;
        settle();
        chk("to_pulse", 32'(o_timeout), 1);
        chk("to_grant_end", 32'(o_grant), 0);
        chk("idle_ack_ignored", 32'(bus.o_m_wb_ack), 0);
        tick();
        bus.i_wb_ack = 1'b0;
        settle();
        chk("to_pulse_once", 32'(o_timeout), 0);

        // load, ack exactly in 4th BUSY cycle -> no timeout
        bus.i_m_wb_cyc = 3'b010;
        tick(); settle();
        chk("ta_grant", 32'(o_grant), 32'h2);
        tick(); tick(); tick();
        bus.i_wb_ack = 1'b1;
        settle();
        chk("ta_ack", 32'(bus.o_m_wb_ack), 32'h2);
        chk("ta_err", 32'(bus.o_m_wb_err), 0);
        tick();
        bus.i_wb_ack   = 1'b0;
        bus.i_m_wb_cyc = 3'b000;
        settle();
        chk("ta_no_pulse", 32'(o_timeout), 0);
        chk("ta_grant_end", 32'(o_grant), 0);

        // fetch, ack and err together
        bus.i_m_wb_cyc = 3'b001;
        tick(); settle();
        chk("ae_grant", 32'(o_grant), 32'h1);
        bus.i_wb_ack = 1'b1;
        bus.i_wb_err = 1'b1;
        settle();
        chk("ae_ack", 32'(bus.o_m_wb_ack), 32'h1);
        chk("ae_err", 32'(bus.o_m_wb_err), 32'h1);
        tick();
        bus.i_wb_ack   = 1'b0;
        bus.i_wb_err   = 1'b0;
        bus.i_m_wb_cyc = 3'b000;
        settle();
        chk("ae_grant_end", 32'(o_grant), 0);
        tick(); settle();
        chk("ae_single_end", 32'(o_grant), 0);

        // fetch granted, asynchronous reset mid-BUSY
        bus.i_m_wb_cyc = 3'b001;
        tick(); settle();
        chk("rb_grant", 32'(o_grant), 32'h1);
        chk("rb_cyc", 32'(bus.o_wb_cyc), 1);
        i_reset_n = 1'b0;
        settle();
        chk("rb_cyc_async", 32'(bus.o_wb_cyc), 0);
        chk("rb_grant_async", 32'(o_grant), 0);
        bus.i_wb_ack = 1'b1;
        settle();
        chk("rb_ack_blocked", 32'(bus.o_m_wb_ack), 0);
        bus.i_wb_ack   = 1'b0;
        bus.i_m_wb_cyc = 3'b101;
        tick(); tick();
        i_reset_n = 1'b1;
        tick(); settle();
        chk("rb_first_fetch", 32'(o_grant), 32'h1);

        // fetch drops cyc in 2nd BUSY cycle, late ack afterwards
        tick();
        bus.i_m_wb_cyc = 3'b100;
        settle();
        chk("dr_cyc_low", 32'(bus.o_wb_cyc), 0);
        chk("dr_no_ack", 32'(bus.o_m_wb_ack), 0);
        tick();
        bus.i_wb_ack = 1'b1;
        settle();
        chk("dr_late_ack", 32'(bus.o_m_wb_ack), 0);
        chk("dr_idle", 32'(o_grant), 0);
        tick();
        bus.i_wb_ack = 1'b0;
        settle();
        chk("dr_store_grant", 32'(o_grant), 32'h4);
        chk("dr_store_cyc", 32'(bus.o_wb_cyc), 1);
        bus.i_wb_ack = 1'b1;
        settle();
        chk("dr_store_ack", 32'(bus.o_m_wb_ack), 32'h4);
        tick();
        bus.i_wb_ack   = 1'b0;
        bus.i_m_wb_cyc = 3'b000;
        settle();
        chk("dr_end", 32'(o_grant), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
